// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between the core memory stage and a
// 32-bit word-addressed data memory. One request per handshake, lane byte
// enables, store data replication, bounded-wait memory handshake and
// sign/zero-extended load return with a single-cycle response strobe.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] Address,
    input  logic [1:0]  DataType,
    input  logic        Unsigned,
    input  logic [31:0] WriteData,
    output logic        resp_valid,
    output logic [31:0] ReadData,
    output logic        Misaligned,
    output logic        BusError,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  ByteEnable,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // Last ACCESS cycle index: the wait counter starts at 0 on entry, so
    // reaching this value means mem_en has been high for TIMEOUT cycles.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [7:0]  wait_cnt;
    logic        write_q;
    logic        unsigned_q;
    logic [1:0]  dtype_q;
    logic [1:0]  off_q;
    logic [29:0] word_addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] rdata_q;
    logic        misaligned_q;
    logic        bus_error_q;

    // Request decode, evaluated on the incoming fields while IDLE
    logic [1:0]  off;
    logic        is_byte;
    logic        is_half;
    logic        misaligned_req;
    logic [3:0]  be_req;
    logic [31:0] wdata_req;

    // Load extraction from the memory word, using the latched request fields
    logic        cap_byte;
    logic        cap_half;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;

    // Decode size, alignment, lane enables and replicated store data
    always_comb begin
        off            = Address[1:0];
        is_byte        = (DataType == 2'b00);
        is_half        = (DataType == 2'b01);
        misaligned_req = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
        if (is_byte) begin
            be_req    = 4'b0001 << off;
            wdata_req = {4{WriteData[7:0]}};
        end else if (is_half) begin
            be_req    = off[1] ? 4'b1100 : 4'b0011;
            wdata_req = {2{WriteData[15:0]}};
        end else begin
            be_req    = 4'b1111;
            wdata_req = WriteData;
        end
    end

    // Select the addressed lane(s) of the read word and extend to 32 bits
    always_comb begin
        cap_byte = (dtype_q == 2'b00);
        cap_half = (dtype_q == 2'b01);
        case (off_q)
            2'd0:    sel_byte = mem_rdata[7:0];
            2'd1:    sel_byte = mem_rdata[15:8];
            2'd2:    sel_byte = mem_rdata[23:16];
            default: sel_byte = mem_rdata[31:24];
        endcase
        sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (cap_byte) begin
            load_ext = {{24{!unsigned_q && sel_byte[7]}}, sel_byte};
        end else if (cap_half) begin
            load_ext = {{16{!unsigned_q && sel_half[15]}}, sel_half};
        end else begin
            load_ext = mem_rdata;
        end
    end

    // Sequencer state, request latch, wait counter and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            wait_cnt     <= 8'd0;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            dtype_q      <= 2'b00;
            off_q        <= 2'b00;
            word_addr_q  <= 30'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            rdata_q      <= 32'd0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q      <= req_write;
                        unsigned_q   <= Unsigned;
                        dtype_q      <= DataType;
                        off_q        <= off;
                        word_addr_q  <= Address[31:2];
                        wdata_q      <= wdata_req;
                        be_q         <= be_req;
                        wait_cnt     <= 8'd0;
                        rdata_q      <= 32'd0;
                        bus_error_q  <= 1'b0;
                        misaligned_q <= misaligned_req;
                        state        <= misaligned_req ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        // Stores report zero read data
                        rdata_q <= write_q ? 32'd0 : load_ext;
                        state   <= S_RESP;
                    end else if (wait_cnt == LAST_WAIT) begin
                        bus_error_q <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from state so reset removes mem_en at once
    always_comb begin
        req_ready  = (state == S_IDLE);
        mem_en     = (state == S_ACCESS);
        mem_we     = (state == S_ACCESS) && write_q;
        ByteEnable = (state == S_ACCESS) ? be_q : 4'd0;
        mem_addr   = {word_addr_q, 2'b00};
        mem_wdata  = wdata_q;
        resp_valid = (state == S_RESP);
        ReadData   = (state == S_RESP) ? rdata_q : 32'd0;
        Misaligned = (state == S_RESP) && misaligned_q;
        BusError   = (state == S_RESP) && bus_error_q;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a scripted driver sets per-cycle expectations
// computed from access-size arithmetic; one compare process checks every
// DUT output on each falling edge. Directed cases pin the model with literals.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] Address;
    logic [1:0]  DataType;
    logic        Unsigned;
    logic [31:0] WriteData;
    logic        resp_valid;
    logic [31:0] ReadData;
    logic        Misaligned;
    logic        BusError;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  ByteEnable;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .Address(Address), .DataType(DataType), .Unsigned(Unsigned),
        .WriteData(WriteData),
        .resp_valid(resp_valid), .ReadData(ReadData),
        .Misaligned(Misaligned), .BusError(BusError),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .ByteEnable(ByteEnable),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected outputs for the current cycle
    logic        exp_reset;
    logic        exp_ready, exp_en, exp_we, exp_resp, exp_mis, exp_berr;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;

    int          en_cnt;
    logic [31:0] cap_addr, cap_wdata, cap_rd;
    logic [3:0]  cap_be;
    logic        cap_mis, cap_berr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int size_of(input logic [1:0] dt);
        return (dt == 2'b00) ? 1 : (dt == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic model_mis(input logic [31:0] a, input logic [1:0] dt);
        return (int'(a[1:0]) % size_of(dt)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] dt);
        int sz = size_of(dt);
        return 4'(((1 << sz) - 1) << int'(a[1:0]));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] dt);
        int sz = size_of(dt);
        logic [31:0] lane;
        if (sz == 4) return wd;
        lane = wd & ((32'd1 << (8 * sz)) - 32'd1);
        return lane * ((sz == 1) ? 32'h0101_0101 : 32'h0001_0001);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] rd, input logic [31:0] a,
                                               input logic [1:0] dt, input logic uns);
        int sz = size_of(dt);
        int w  = 8 * sz;
        logic [31:0] v, mask;
        if (sz == 4) return rd;
        v    = rd >> (8 * int'(a[1:0]));
        mask = (32'd1 << w) - 32'd1;
        v    = v & mask;
        if (!uns && v[w-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_idle();
        exp_ready = 1'b1; exp_en = 1'b0; exp_we = 1'b0; exp_resp = 1'b0;
        exp_mis = 1'b0; exp_berr = 1'b0; exp_be = 4'd0;
        exp_addr = 32'd0; exp_wdata = 32'd0; exp_rd = 32'd0;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (mem_en === 1'b1) en_cnt++;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("mem_en", 32'(mem_en), 32'(exp_en));
        chk("resp_valid", 32'(resp_valid), 32'(exp_resp));
        chk("ByteEnable", 32'(ByteEnable), 32'(exp_be));
        if (exp_en || exp_reset) begin
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_wdata);
        end
        if (exp_resp || exp_reset) begin
            chk("ReadData", ReadData, exp_rd);
            chk("Misaligned", 32'(Misaligned), 32'(exp_mis));
            chk("BusError", 32'(BusError), 32'(exp_berr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, access (or reject), response, idle gap
    task automatic do_txn(input logic wr, input logic [31:0] a, input logic [1:0] dt,
                          input logic uns, input logic [31:0] wd, input logic [31:0] rd,
                          input int waits, input int gap);
        logic mis = model_mis(a, dt);
        en_cnt    = 0;
        req_valid = 1'b1; req_write = wr; Address = a; DataType = dt;
        Unsigned  = uns; WriteData = wd; mem_ack = 1'b0; mem_rdata = $urandom;
        set_idle();
        step();
        req_valid = 1'b0;
        Address   = $urandom; DataType = 2'($urandom); WriteData = $urandom;
        if (mis) begin
            set_idle();
            exp_ready = 1'b0; exp_resp = 1'b1; exp_mis = 1'b1;
        end else begin
            for (int i = 0; ; i++) begin
                set_idle();
                exp_ready = 1'b0; exp_en = 1'b1; exp_we = wr;
                exp_addr  = {a[31:2], 2'b00};
                exp_wdata = model_wdata(wd, dt);
                exp_be    = model_be(a, dt);
                mem_ack   = (i == waits);
                mem_rdata = (i == waits) ? rd : $urandom;
                if (i == 0) begin
                    cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = ByteEnable;
                end
                step();
                mem_ack = 1'b0;
                if (i == waits) begin
                    set_idle();
                    exp_ready = 1'b0; exp_resp = 1'b1;
                    exp_rd = wr ? 32'd0 : model_read(rd, a, dt, uns);
                    break;
                end
                if (i == TO - 1) begin
                    set_idle();
                    exp_ready = 1'b0; exp_resp = 1'b1; exp_berr = 1'b1;
                    break;
                end
            end
        end
        // Response cycle: a request and stray ack here must both be ignored
        cap_rd = ReadData; cap_mis = Misaligned; cap_berr = BusError;
        req_valid = 1'($urandom); mem_ack = 1'($urandom); mem_rdata = $urandom;
        step();
        req_valid = 1'b0;
        set_idle();
        for (int g = 0; g < gap; g++) begin
            mem_ack = 1'($urandom); mem_rdata = $urandom;
            step();
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        exp_reset = 1'b1;
        set_idle();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; Address = 32'd0;
        DataType = 2'b00; Unsigned = 1'b0; WriteData = 32'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0; en_cnt = 0;
        step(); step();
        rst_n = 1'b0;
        exp_reset = 1'b0;
        rst_n = 1'b1;
        step();

        // Byte store at offset 3, immediate ack
        do_txn(1'b1, 32'h0000_1003, 2'b00, 1'b0, 32'h0000_00AB, 32'h0, 0, 0);
        chk("bst_addr", cap_addr, 32'h0000_1000);
        chk("bst_be", 32'(cap_be), 32'h8);
        chk("bst_wdata", cap_wdata, 32'hABAB_ABAB);
        chk("bst_rd", cap_rd, 32'h0);

        // Half loads at offset 2, three waits, signed then unsigned
        do_txn(1'b0, 32'h0000_2002, 2'b01, 1'b0, 32'h0, 32'h8001_1234, 3, 1);
        chk("hld_be", 32'(cap_be), 32'hC);
        chk("hld_signed", cap_rd, 32'hFFFF_8001);
        do_txn(1'b0, 32'h0000_2002, 2'b01, 1'b1, 32'h0, 32'h8001_1234, 3, 0);
        chk("hld_unsigned", cap_rd, 32'h0000_8001);

        // Byte load at offset 1
        do_txn(1'b0, 32'h0000_0041, 2'b00, 1'b0, 32'h0, 32'h0000_7F00, 1, 0);
        chk("bld_rd", cap_rd, 32'h0000_007F);

        // Misaligned word and half
        do_txn(1'b0, 32'h0000_3001, 2'b10, 1'b0, 32'h0, 32'h0, 0, 0);
        chk("mis_word", 32'(cap_mis), 32'h1);
        chk("mis_word_en", 32'(en_cnt), 32'h0);
        do_txn(1'b1, 32'h0000_3003, 2'b01, 1'b0, 32'h1234, 32'h0, 0, 0);
        chk("mis_half", 32'(cap_mis), 32'h1);
        chk("mis_half_en", 32'(en_cnt), 32'h0);

        // Timeout, then ack in the final access cycle
        do_txn(1'b0, 32'h0000_4000, 2'b10, 1'b0, 32'h0, 32'h0, 50, 0);
        chk("to_berr", 32'(cap_berr), 32'h1);
        chk("to_en_cycles", 32'(en_cnt), 32'(TO));
        do_txn(1'b0, 32'h0000_4000, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, TO - 1, 0);
        chk("late_ack_berr", 32'(cap_berr), 32'h0);
        chk("late_ack_rd", cap_rd, 32'hCAFE_F00D);
        chk("late_ack_en_cycles", 32'(en_cnt), 32'(TO));

        // Reset two cycles into an access wait
        req_valid = 1'b1; req_write = 1'b1; Address = 32'h0000_5000;
        DataType = 2'b10; WriteData = 32'h1111_2222; mem_ack = 1'b0;
        set_idle();
        step();
        req_valid = 1'b0;
        exp_ready = 1'b0; exp_en = 1'b1; exp_we = 1'b1; exp_addr = 32'h0000_5000;
        exp_wdata = 32'h1111_2222; exp_be = 4'hF;
        step();
        step();
        #2;
        exp_reset = 1'b1;
        set_idle();
        rst_n = 1'b0;
        #1;
        chk("rst_async_mem_en", 32'(mem_en), 32'h0);
        chk("rst_async_ready", 32'(req_ready), 32'h1);
        step();
        step();
        rst_n = 1'b1;
        exp_reset = 1'b0;
        step();
        do_txn(1'b1, 32'h0000_6004, 2'b11, 1'b0, 32'hDEAD_BEEF, 32'h0, 1, 0);
        chk("post_rst_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("post_rst_be", 32'(cap_be), 32'hF);
        chk("post_rst_berr", 32'(cap_berr), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            do_txn(1'($urandom), $urandom, 2'($urandom), 1'($urandom), $urandom,
                   $urandom, int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer between the RISC-V core's memory stage and the 32-bit word-addressed data memory. Accepts one load or store per handshake and generates the per-lane byte enables. It replicates store data onto the active lanes and drives a variable-latency memory handshake. It then extracts and sign/zero-extends load data and returns a single-cycle response. Misaligned accesses and memory timeouts are reported to the core and never reach memory, or are aborted.

## Interface
- TIMEOUT, 15: max ACCESS cycles without `mem_ack` before abort (1..255)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  controller can accept (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- Address  in  32  byte address (ALU result)
- DataType  in  2  00 byte, 01 half, 10 word, 11 treated as word
- Unsigned  in  1  load zero-extends when 1, sign-extends when 0
- WriteData  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response strobe
- ReadData  out  32  extended load data, valid with resp_valid on loads
- Misaligned  out  1  with resp_valid: request rejected, no memory access
- BusError  out  1  with resp_valid: memory timed out
- mem_en  out  1  memory access request
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  32  {Address[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- ByteEnable  out  4  active byte lanes
- mem_ack  in  1  memory completes access this cycle
- mem_rdata  in  32  read word, valid with mem_ack

## Operation
- FSM states: IDLE, ACCESS, RESP. Encoding is free.
- IDLE: req_ready=1. On req_valid, latch all request fields and compute `off = Address[1:0]`.
  - Misaligned when half and off[0]=1, or word/11 and off≠0. Then go to RESP with Misaligned=1 and no mem_en.
  - Otherwise go to ACCESS and clear the timeout counter.
- ByteEnable: byte → 4'b0001 << off; half → off[1] ? 4'b1100 : 4'b0011; word → 4'b1111. Driven only in ACCESS, 0 elsewhere.
- mem_wdata: byte → {4{WriteData[7:0]}}; half → {2{WriteData[15:0]}}; word → WriteData.
- ACCESS behaviour:
  - mem_en=1, and mem_we=req_write.
  - mem_addr, mem_wdata, ByteEnable and mem_we stay stable until exit.
  - On mem_ack, capture mem_rdata and go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without an ack, go to RESP with BusError=1.
- Load extraction from the captured word:
  - byte → word >> (8·off), then bits [7:0] extended.
  - half → word >> (16·off[1]), then bits [15:0] extended.
  - word → unchanged.
- Stores leave ReadData at 0 in their response.
- RESP: resp_valid=1 for exactly one cycle, with ReadData, Misaligned and BusError valid. Then go to IDLE.
- Misaligned and BusError are mutually exclusive.
- mem_ack outside ACCESS is ignored.
- A new request is not accepted in RESP. No back-to-back acceptance.

## Timing
- Reset (async assert): state=IDLE, req_ready=1.
  - mem_en, mem_we, resp_valid, Misaligned and BusError all 0.
  - ByteEnable, mem_addr, mem_wdata and ReadData all 0.
- Reset during ACCESS: mem_en drops immediately and the request is discarded with no response.
- Latency: request accepted at edge 0, so ACCESS starts at cycle 1. An ack seen at cycle k gives resp_valid at cycle k+1. The minimum is 2 cycles accept→response.
- Misaligned path: resp_valid in the cycle after acceptance, with zero memory cycles.
- Timeout: mem_en is high for exactly TIMEOUT cycles, then resp_valid with BusError. An ack arriving in the final ACCESS cycle wins over the timeout.
- Request→re-acceptance throughput: ≥3 cycles per access.

## Test plan
- Byte store: Address=0x1003, WriteData=0xAB, ack after 0 waits → mem_addr=0x1000, ByteEnable=1000, mem_wdata=0xABABABAB, resp_valid at cycle 2.
- Half load, signed: Address=0x2002, mem_rdata=0x8001_1234, 3 wait cycles → ByteEnable=1100, ReadData=0xFFFF8001; with Unsigned=1 → 0x00008001.
- Byte load at offset 1: mem_rdata=0x0000_7F00, Unsigned=0 → ReadData=0x0000007F.
- Misaligned: word at 0x3001 and half at 0x3003 → Misaligned=1 the cycle after acceptance, mem_en never high.
- Timeout: TIMEOUT=4, mem_ack held low → mem_en high exactly 4 cycles, then BusError=1 with resp_valid. Repeat with ack on the 4th cycle → normal response, BusError=0.
- Reset mid-ACCESS: assert rst_n=0 two cycles into a wait → mem_en=0 asynchronously, no resp_valid. After release, req_ready=1 and the next word store completes normally.
